fetch_seq_ctrl: RTL and testbench

Sequencing controller for the 4-wide fetch stage. Each cycle it selects the next-PC source and gates the PC register write. It also qualifies the instruction bundle sent to decode and sequences the multi-cycle recovery and register-jump wait episodes. It replaces free-running next-PC selection with an explicit state machine that the fetch top instantiates between the branch/jump handlers and the PC mux.

---
 rtl/fetch_seq_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_fetch_seq_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl: next-PC source select, PC write gating and bundle qualify.
// Optional jump-wait timeout is built when FETCH_JWAIT_TIMEOUT_EN is defined.
module fetch_seq_ctrl #(
   parameter int RECOV_CYCLES = 2,
   parameter int JWAIT_MAX    = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_fetch,
   input  logic        has_mispredict,
   input  logic [1:0]  pred_to_pcsel,
   input  logic        pcsel_from_bhndlr,
   input  logic        jump_for_pcsel,
   input  logic        stall_for_jump,
   input  logic        jump_base_rdy,
   output logic [2:0]  pc_sel,
   output logic        pc_we,
   output logic        fetch_vld,
   output logic        flush_dec,
   output logic [2:0]  fsm_state,
   output logic [15:0] redirect_cnt,
   output logic        jwait_timeout
);

   localparam logic [2:0] SEL_REC    = 3'd0;
   localparam logic [2:0] SEL_BR0    = 3'd1;
   localparam logic [2:0] SEL_BR1    = 3'd2;
   localparam logic [2:0] SEL_JUMP   = 3'd3;
   localparam logic [2:0] SEL_PLUS4  = 3'd4;
   localparam logic [2:0] SEL_BHNDLR = 3'd5;
   localparam logic [2:0] SEL_HOLD   = 3'd6;

   localparam logic [2:0] RCNT_INIT = 3'(RECOV_CYCLES);

   typedef enum logic [2:0] {
      ST_BOOT  = 3'd0,
      ST_RUN   = 3'd1,
      ST_JWAIT = 3'd2,
      ST_RECOV = 3'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] rcnt;
   logic [2:0] rcnt_nxt;
   logic       jump_go;
   logic       to_hit;
   logic       redir;

   generate
      if (RECOV_CYCLES < 1 || RECOV_CYCLES > 7) begin : g_bad_recov
         $error("RECOV_CYCLES out of range 1..7");
      end
      if (JWAIT_MAX < 1 || JWAIT_MAX > 255) begin : g_bad_jwait
         $error("JWAIT_MAX out of range 1..255");
      end
   endgenerate

   // Register jump completes only when the base is here and fetch can move.
   assign jump_go = jump_base_rdy && !stall_fetch;
   assign redir   = (pc_sel != SEL_PLUS4) && (pc_sel != SEL_HOLD);
   assign fsm_state = state;

`ifdef FETCH_JWAIT_TIMEOUT_EN
   localparam logic [7:0] WCNT_MAX = 8'(JWAIT_MAX);

   logic [7:0] wcnt;
   logic       timeout_q;

   assign to_hit        = !jump_base_rdy && (wcnt >= WCNT_MAX);
   assign jwait_timeout = timeout_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wcnt      <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == ST_RUN && state_nxt == ST_JWAIT) begin
            wcnt <= '0;
         end else if (state == ST_JWAIT && !pc_we && wcnt != 8'hFF) begin
            wcnt <= wcnt + 8'd1;
         end
         // A PLUS4 load out of JWAIT can only be the timeout release.
         if (state == ST_JWAIT && pc_we && pc_sel == SEL_PLUS4) begin
            timeout_q <= 1'b1;
         end
      end
   end
`else
   assign to_hit        = 1'b0;
   assign jwait_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_BOOT;
         rcnt         <= '0;
         redirect_cnt <= '0;
      end else begin
         state <= state_nxt;
         rcnt  <= rcnt_nxt;
         if (pc_we && redir && redirect_cnt != 16'hFFFF) begin
            redirect_cnt <= redirect_cnt + 16'd1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      unique case (state)
         ST_BOOT: begin
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (has_mispredict) begin
               state_nxt = ST_RECOV;
               rcnt_nxt  = RCNT_INIT;
            end else if (!stall_fetch && stall_for_jump) begin
               state_nxt = ST_JWAIT;
            end
         end
         ST_JWAIT: begin
            if (has_mispredict) begin
               state_nxt = ST_RECOV;
               rcnt_nxt  = RCNT_INIT;
            end else if (jump_go || to_hit) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RECOV: begin
            if (has_mispredict) begin
               rcnt_nxt = RCNT_INIT;
            end else begin
               rcnt_nxt = rcnt - 3'd1;
               if (rcnt <= 3'd1) begin
                  state_nxt = ST_RUN;
               end
            end
         end
         default: begin
            state_nxt = ST_BOOT;
         end
      endcase
   end

   always_comb begin
      pc_sel    = SEL_HOLD;
      pc_we     = 1'b0;
      fetch_vld = 1'b0;
      flush_dec = 1'b0;
      if (rst_n) begin
         unique case (state)
            ST_RUN: begin
               if (has_mispredict) begin
                  pc_sel    = SEL_REC;
                  pc_we     = 1'b1;
                  flush_dec = 1'b1;
               end else if (stall_fetch) begin
                  pc_sel = SEL_HOLD;
               end else if (stall_for_jump) begin
                  fetch_vld = 1'b1;
               end else begin
                  pc_we     = 1'b1;
                  fetch_vld = 1'b1;
                  if (jump_for_pcsel) begin
                     pc_sel = SEL_JUMP;
                  end else if (pred_to_pcsel[0]) begin
                     pc_sel = SEL_BR0;
                  end else if (pred_to_pcsel[1]) begin
                     pc_sel = SEL_BR1;
                  end else if (pcsel_from_bhndlr) begin
                     pc_sel = SEL_BHNDLR;
                  end else begin
                     pc_sel = SEL_PLUS4;
                  end
               end
            end
            ST_JWAIT: begin
               if (has_mispredict) begin
                  pc_sel    = SEL_REC;
                  pc_we     = 1'b1;
                  flush_dec = 1'b1;
               end else if (jump_go) begin
                  pc_sel = SEL_JUMP;
                  pc_we  = 1'b1;
               end else if (to_hit) begin
                  pc_sel = SEL_PLUS4;
                  pc_we  = 1'b1;
               end
            end
            ST_RECOV: begin
               if (has_mispredict) begin
                  pc_sel    = SEL_REC;
                  pc_we     = 1'b1;
                  flush_dec = 1'b1;
               end
            end
            default: begin
               pc_sel = SEL_HOLD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb_fetch_seq_ctrl: directed scenarios plus randomized run against a
// behavioural model of the fetch sequencing rules.
module tb_fetch_seq_ctrl;

   localparam int RC = 2;
   localparam int JM = 15;
`ifdef FETCH_JWAIT_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_fetch;
   logic        has_mispredict;
   logic [1:0]  pred_to_pcsel;
   logic        pcsel_from_bhndlr;
   logic        jump_for_pcsel;
   logic        stall_for_jump;
   logic        jump_base_rdy;
   logic [2:0]  pc_sel;
   logic        pc_we;
   logic        fetch_vld;
   logic        flush_dec;
   logic [2:0]  fsm_state;
   logic [15:0] redirect_cnt;
   logic        jwait_timeout;

   int n_checks = 0;
   int n_pass   = 0;

   // model: 0 boot, 1 running, 2 waiting for jump base, 3 recovering
   int m_mode;
   int m_bubbles;
   int m_waited;
   int m_redir;
   bit m_to;

   wire [5:0] outs = {pc_sel, pc_we, fetch_vld, flush_dec};

   fetch_seq_ctrl #(.RECOV_CYCLES(RC), .JWAIT_MAX(JM)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .stall_fetch(stall_fetch),
      .has_mispredict(has_mispredict),
      .pred_to_pcsel(pred_to_pcsel),
      .pcsel_from_bhndlr(pcsel_from_bhndlr),
      .jump_for_pcsel(jump_for_pcsel),
      .stall_for_jump(stall_for_jump),
      .jump_base_rdy(jump_base_rdy),
      .pc_sel(pc_sel),
      .pc_we(pc_we),
      .fetch_vld(fetch_vld),
      .flush_dec(flush_dec),
      .fsm_state(fsm_state),
      .redirect_cnt(redirect_cnt),
      .jwait_timeout(jwait_timeout)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic m, input logic sf, input logic [1:0] p,
                        input logic b, input logic j, input logic sj,
                        input logic r);
      has_mispredict    = m;
      stall_fetch       = sf;
      pred_to_pcsel     = p;
      pcsel_from_bhndlr = b;
      jump_for_pcsel    = j;
      stall_for_jump    = sj;
      jump_base_rdy     = r;
   endtask

   task automatic idle();
      drive(0, 0, 2'b00, 0, 0, 0, 0);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // expected combinational outputs for the current model state and inputs
   function automatic logic [5:0] model_out();
      logic [2:0] s;
      logic w, v, f;
      s = 3'd6; w = 0; v = 0; f = 0;
      if (rst_n && m_mode != 0) begin
         if (m_mode == 1) begin
            if (has_mispredict) begin
               s = 3'd0; w = 1; f = 1;
            end else if (stall_fetch) begin
               s = 3'd6;
            end else if (stall_for_jump) begin
               v = 1;
            end else begin
               w = 1; v = 1;
               s = jump_for_pcsel    ? 3'd3 :
                   pred_to_pcsel[0]  ? 3'd1 :
                   pred_to_pcsel[1]  ? 3'd2 :
                   pcsel_from_bhndlr ? 3'd5 : 3'd4;
            end
         end else if (has_mispredict) begin
            s = 3'd0; w = 1; f = 1;
         end else if (m_mode == 2) begin
            if (jump_base_rdy && !stall_fetch) begin
               s = 3'd3; w = 1;
            end else if (TO_EN && !jump_base_rdy && m_waited >= JM) begin
               s = 3'd4; w = 1;
            end
         end
      end
      return {s, w, v, f};
   endfunction

   task automatic model_step(input logic [5:0] o);
      logic [2:0] s;
      logic w;
      s = o[5:3];
      w = o[2];
      if (!rst_n) begin
         m_mode = 0; m_bubbles = 0; m_waited = 0; m_redir = 0; m_to = 0;
         return;
      end
      if (w && s != 3'd4 && s != 3'd6 && m_redir < 65535) m_redir++;
      case (m_mode)
         0: m_mode = 1;
         1: begin
            if (has_mispredict) begin
               m_mode = 3; m_bubbles = RC;
            end else if (!stall_fetch && stall_for_jump) begin
               m_mode = 2; m_waited = 0;
            end
         end
         2: begin
            if (has_mispredict) begin
               m_mode = 3; m_bubbles = RC;
            end else if (w) begin
               m_mode = 1;
               if (s == 3'd4) m_to = 1;
            end else if (m_waited < 255) begin
               m_waited++;
            end
         end
         default: begin
            if (has_mispredict) begin
               m_bubbles = RC;
            end else begin
               m_bubbles--;
               if (m_bubbles == 0) m_mode = 1;
            end
         end
      endcase
   endtask

   task automatic test_reset();
      rst_n = 0;
      drive(1, 0, 2'b11, 1, 1, 1, 1);
      @(negedge clk);
      n_checks++;
      if (outs !== {3'd6, 3'b000}) $display("FAIL rst_force got %b want %b", outs, {3'd6, 3'b000});
      else n_pass++;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({fsm_state, redirect_cnt, jwait_timeout} !== 20'd0)
         $display("FAIL rst_regs got st=%0d rc=%0d to=%b want 0/0/0", fsm_state, redirect_cnt, jwait_timeout);
      else n_pass++;
      nxt();
      rst_n = 1;
      idle();
      @(negedge clk);
      n_checks++;
      if ({fsm_state, outs} !== {3'd0, 3'd6, 3'b000}) $display("FAIL boot got st=%0d o=%b want st=0 o=110000", fsm_state, outs);
      else n_pass++;
      nxt();
      @(negedge clk);
      n_checks++;
      if ({fsm_state, outs, redirect_cnt} !== {3'd1, 3'd4, 3'b110, 16'd0})
         $display("FAIL run_first got st=%0d o=%b rc=%0d want st=1 o=100110 rc=0", fsm_state, outs, redirect_cnt);
      else n_pass++;
      nxt();
   endtask

   task automatic test_mispredict();
      drive(1, 0, 2'b00, 0, 0, 0, 0);
      @(negedge clk);
      n_checks++;
      if (outs !== {3'd0, 3'b101}) $display("FAIL misp_n got %b want 000101", outs);
      else n_pass++;
      nxt();
      idle();
      for (int i = 1; i <= RC; i++) begin
         @(negedge clk);
         n_checks++;
         if ({fsm_state, outs, redirect_cnt} !== {3'd3, 3'd6, 3'b000, 16'd1})
            $display("FAIL misp_bubble%0d got st=%0d o=%b rc=%0d want st=3 o=110000 rc=1", i, fsm_state, outs, redirect_cnt);
         else n_pass++;
         nxt();
      end
      @(negedge clk);
      n_checks++;
      if ({fsm_state, outs} !== {3'd1, 3'd4, 3'b110}) $display("FAIL misp_resume got st=%0d o=%b want st=1 o=100110", fsm_state, outs);
      else n_pass++;
      nxt();
   endtask

   task automatic test_pred_priority();
      logic [5:0] want [4];
      want[0] = {3'd3, 3'b110};
      want[1] = {3'd2, 3'b110};
      want[2] = {3'd5, 3'b110};
      want[3] = {3'd1, 3'b110};
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: drive(0, 0, 2'b11, 0, 1, 0, 0);
            1: drive(0, 0, 2'b10, 0, 0, 0, 0);
            2: drive(0, 0, 2'b00, 1, 0, 0, 0);
            default: drive(0, 0, 2'b01, 1, 0, 0, 0);
         endcase
         @(negedge clk);
         n_checks++;
         if (outs !== want[i]) $display("FAIL pred%0d got %b want %b", i, outs, want[i]);
         else n_pass++;
         nxt();
      end
      idle();
      @(negedge clk);
      n_checks++;
      if (redirect_cnt !== 16'd5) $display("FAIL pred_redir got %0d want 5", redirect_cnt);
      else n_pass++;
      nxt();
   endtask

   task automatic test_jump_wait();
      drive(0, 0, 2'b00, 0, 0, 1, 0);
      @(negedge clk);
      n_checks++;
      if (outs !== {3'd6, 3'b010}) $display("FAIL jw_enter got %b want 110010", outs);
      else n_pass++;
      nxt();
      idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({fsm_state, outs} !== {3'd2, 3'd6, 3'b000}) $display("FAIL jw_hold%0d got st=%0d o=%b want st=2 o=110000", i, fsm_state, outs);
         else n_pass++;
         nxt();
      end
      drive(0, 1, 2'b00, 0, 0, 0, 1);
      @(negedge clk);
      n_checks++;
      if ({fsm_state, outs} !== {3'd2, 3'd6, 3'b000}) $display("FAIL jw_stalled got st=%0d o=%b want st=2 o=110000", fsm_state, outs);
      else n_pass++;
      nxt();
      drive(0, 0, 2'b00, 0, 0, 0, 1);
      @(negedge clk);
      n_checks++;
      if (outs !== {3'd3, 3'b100}) $display("FAIL jw_load got %b want 011100", outs);
      else n_pass++;
      nxt();
      idle();
      @(negedge clk);
      n_checks++;
      if ({fsm_state, redirect_cnt} !== {3'd1, 16'd6}) $display("FAIL jw_exit got st=%0d rc=%0d want st=1 rc=6", fsm_state, redirect_cnt);
      else n_pass++;
      nxt();
   endtask

   task automatic test_recov_restart();
      drive(1, 0, 2'b00, 0, 0, 0, 0);
      @(negedge clk);
      nxt();
      idle();
      @(negedge clk);
      n_checks++;
      if ({fsm_state, outs} !== {3'd3, 3'd6, 3'b000}) $display("FAIL rr_b1 got st=%0d o=%b want st=3 o=110000", fsm_state, outs);
      else n_pass++;
      nxt();
      drive(1, 0, 2'b00, 0, 0, 0, 0);
      @(negedge clk);
      n_checks++;
      if (outs !== {3'd0, 3'b101}) $display("FAIL rr_reflush got %b want 000101", outs);
      else n_pass++;
      nxt();
      idle();
      for (int i = 0; i < RC; i++) begin
         @(negedge clk);
         n_checks++;
         if ({fsm_state, outs} !== {3'd3, 3'd6, 3'b000}) $display("FAIL rr_bubble%0d got st=%0d o=%b want st=3 o=110000", i, fsm_state, outs);
         else n_pass++;
         nxt();
      end
      @(negedge clk);
      n_checks++;
      if ({fsm_state, outs, redirect_cnt} !== {3'd1, 3'd4, 3'b110, 16'd8})
         $display("FAIL rr_resume got st=%0d o=%b rc=%0d want st=1 o=100110 rc=8", fsm_state, outs, redirect_cnt);
      else n_pass++;
      nxt();
   endtask

   task automatic test_jwait_long();
      drive(0, 0, 2'b00, 0, 0, 1, 0);
      @(negedge clk);
      nxt();
      idle();
      for (int i = 0; i < JM; i++) begin
         @(negedge clk);
         n_checks++;
         if ({fsm_state, outs} !== {3'd2, 3'd6, 3'b000}) $display("FAIL jl_hold%0d got st=%0d o=%b want st=2 o=110000", i, fsm_state, outs);
         else n_pass++;
         nxt();
      end
      @(negedge clk);
`ifdef FETCH_JWAIT_TIMEOUT_EN
      n_checks++;
      if (outs !== {3'd4, 3'b100}) $display("FAIL jl_timeout got %b want 100100", outs);
      else n_pass++;
      nxt();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if ({fsm_state, jwait_timeout, redirect_cnt} !== {3'd1, 1'b1, 16'd8})
            $display("FAIL jl_sticky%0d got st=%0d to=%b rc=%0d want st=1 to=1 rc=8", i, fsm_state, jwait_timeout, redirect_cnt);
         else n_pass++;
         nxt();
      end
`else
      n_checks++;
      if ({outs, jwait_timeout} !== {3'd6, 3'b000, 1'b0}) $display("FAIL jl_nowrap got o=%b to=%b want o=110000 to=0", outs, jwait_timeout);
      else n_pass++;
      nxt();
      drive(0, 0, 2'b00, 0, 0, 0, 1);
      @(negedge clk);
      nxt();
      idle();
      @(negedge clk);
      n_checks++;
      if ({fsm_state, redirect_cnt} !== {3'd1, 16'd9}) $display("FAIL jl_exit got st=%0d rc=%0d want st=1 rc=9", fsm_state, redirect_cnt);
      else n_pass++;
      nxt();
`endif
   endtask

   task automatic test_random();
      logic [5:0] exp_o;
      rst_n = 0;
      idle();
      for (int c = 0; c < 4000; c++) begin
         if (c >= 2) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                  2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0);
         end
         @(negedge clk);
         exp_o = model_out();
         n_checks++;
         if (outs !== exp_o) $display("FAIL rnd_outs c=%0d got %b want %b", c, outs, exp_o);
         else n_pass++;
         if (c >= 1) begin
            n_checks++;
            if ({fsm_state, redirect_cnt, jwait_timeout} !== {3'(m_mode), 16'(m_redir), m_to})
               $display("FAIL rnd_regs c=%0d got st=%0d rc=%0d to=%b want st=%0d rc=%0d to=%b",
                        c, fsm_state, redirect_cnt, jwait_timeout, m_mode, m_redir, m_to);
            else n_pass++;
         end
         model_step(exp_o);
         nxt();
      end
   endtask

   initial begin
      rst_n = 0;
      idle();
      m_mode = 0; m_bubbles = 0; m_waited = 0; m_redir = 0; m_to = 0;
      #1;
      test_reset();
      test_mispredict();
      test_pred_priority();
      test_jump_wait();
      test_recov_restart();
      test_jwait_long();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
